// File: rtl/psk_symbol_scheduler_pkg.sv
// rtl/psk_symbol_scheduler_pkg.sv - shared types and constants for the PSK symbol scheduler
//
// Purpose : scheduler state enumeration, the two BPSK phase offsets and a
//           helper that maps a payload bit to its phase offset.
// Ports   : none (package).
package psk_symbol_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_TAIL     = 2'd3
   } sched_state_t;

   localparam logic [15:0] PHASE_0   = 16'h0000;
   localparam logic [15:0] PHASE_180 = 16'h8000;

   function automatic logic [15:0] bit_phase(input logic b);
      return b ? PHASE_180 : PHASE_0;
   endfunction

endpackage

// File: rtl/psk_symbol_scheduler_bit_fifo.sv
// rtl/psk_symbol_scheduler_bit_fifo.sv - small show-ahead FIFO holding {last, data} payload bits
//
// Purpose : buffers payload bits between the bit source and the symbol
//           scheduler. rd_data always presents the oldest entry.
// Ports   : clk, rst_n (async active-low)
//           flush            - synchronous clear of all entries
//           wr_en, wr_data   - push request and 2-bit entry {last, data}
//           rd_en, rd_data   - pop request and head entry
//           full, empty      - registered occupancy flags
//           ready            - registered "can accept", low while in reset
module bit_fifo
   import psk_symbol_scheduler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       wr_en,
   input  logic [1:0] wr_data,
   input  logic       rd_en,
   output logic [1:0] rd_data,
   output logic       full,
   output logic       empty,
   output logic       ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_n;
   logic          do_wr;
   logic          do_rd;

   // Guard against overflow/underflow even if a caller misbehaves.
   assign do_wr   = wr_en && !full && !flush;
   assign do_rd   = rd_en && !empty && !flush;
   assign count_n = count + CW'(do_wr) - CW'(do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // ready resets low so the source sees no acceptance until the first
   // edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ready  <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ready  <= 1'b1;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_n;
         full  <= (count_n == CW'(DEPTH));
         empty <= (count_n == '0);
         ready <= (count_n != CW'(DEPTH));
      end
   end

endmodule

// File: rtl/psk_symbol_scheduler.sv
// rtl/psk_symbol_scheduler.sv - BPSK frame scheduler driving an NCO phase offset per symbol
//
// Purpose : sequences a frame of alternating-phase preamble symbols, one
//           data symbol per queued payload bit, and two zero-phase tail
//           symbols, presenting a fixed frequency word and a per-symbol
//           phase offset to an NCO.
// Ports   : sys_clk, sys_rst_n (async active-low)
//           frame_start  - one-cycle frame request, honoured only in IDLE
//           abort        - synchronous abort and FIFO flush
//           bit_valid/bit_data/bit_last, bit_ready - payload bit input
//           phi_inc      - NCO frequency word (BASE_PHASE)
//           phase_offset - 0 or 180 degree offset for the current symbol
//           nco_en       - NCO run enable
//           sym_strobe   - first cycle of each symbol
//           busy         - frame in progress
//           underrun     - data symbol loaded from an empty FIFO
module psk_symbol_scheduler
   import psk_symbol_scheduler_pkg::*;
#(
   parameter logic [31:0] BASE_PHASE    = 32'd655,
   parameter int          SYM_CYCLES    = 1000,
   parameter int          PREAMBLE_SYMS = 8,
   parameter int          FIFO_DEPTH    = 4
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        frame_start,
   input  logic        abort,
   input  logic        bit_valid,
   input  logic        bit_data,
   input  logic        bit_last,
   output logic        bit_ready,
   output logic [31:0] phi_inc,
   output logic [15:0] phase_offset,
   output logic        nco_en,
   output logic        sym_strobe,
   output logic        busy,
   output logic        underrun
);

   localparam logic [15:0] SYM_LAST = 16'(SYM_CYCLES - 1);
   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_SYMS - 1);

   sched_state_t state_q, state_n;
   logic [15:0]  cnt_q, cnt_n;
   logic [7:0]   pre_q, pre_n;
   logic         tail_q, tail_n;
   logic         last_q, last_n;
   logic [15:0]  phase_n;
   logic         nco_n;
   logic         strobe_n;
   logic         underrun_n;
   logic         busy_n;
   logic         wrap;
   logic         load_data;
   logic         pop;
   logic         push;
   logic [1:0]   fifo_rd_data;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_ready;

   // abort wins over any push in the same cycle.
   assign push      = bit_valid && fifo_ready && !fifo_full && !abort;
   assign bit_ready = fifo_ready;
   assign wrap      = (cnt_q == SYM_LAST);

   bit_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_bit_fifo (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .flush   (abort),
      .wr_en   (push),
      .wr_data ({bit_last, bit_data}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .ready   (fifo_ready)
   );

   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      pre_n      = pre_q;
      tail_n     = tail_q;
      last_n     = last_q;
      phase_n    = phase_offset;
      nco_n      = nco_en;
      strobe_n   = 1'b0;
      underrun_n = 1'b0;
      load_data  = 1'b0;
      pop        = 1'b0;

      if (abort) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         pre_n   = '0;
         tail_n  = 1'b0;
         last_n  = 1'b0;
         phase_n = PHASE_0;
         nco_n   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_n = '0;
               if (frame_start) begin
                  state_n  = ST_PREAMBLE;
                  pre_n    = '0;
                  tail_n   = 1'b0;
                  last_n   = 1'b0;
                  phase_n  = PHASE_0;
                  nco_n    = 1'b1;
                  strobe_n = 1'b1;
               end
            end
            ST_PREAMBLE: begin
               cnt_n = wrap ? '0 : cnt_q + 16'd1;
               if (wrap) begin
                  strobe_n = 1'b1;
                  if (pre_q == PRE_LAST) begin
                     state_n   = ST_DATA;
                     load_data = 1'b1;
                  end else begin
                     pre_n   = pre_q + 8'd1;
                     // Next index has the opposite parity of the current one.
                     phase_n = pre_q[0] ? PHASE_0 : PHASE_180;
                  end
               end
            end
            ST_DATA: begin
               cnt_n = wrap ? '0 : cnt_q + 16'd1;
               if (wrap) begin
                  strobe_n = 1'b1;
                  if (last_q) begin
                     state_n = ST_TAIL;
                     tail_n  = 1'b0;
                     last_n  = 1'b0;
                     phase_n = PHASE_0;
                  end else begin
                     load_data = 1'b1;
                  end
               end
            end
            ST_TAIL: begin
               cnt_n = wrap ? '0 : cnt_q + 16'd1;
               if (wrap) begin
                  if (tail_q) begin
                     state_n = ST_IDLE;
                     nco_n   = 1'b0;
                     phase_n = PHASE_0;
                  end else begin
                     tail_n   = 1'b1;
                     strobe_n = 1'b1;
                  end
               end
            end
            default: begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               phase_n = PHASE_0;
               nco_n   = 1'b0;
            end
         endcase

         // An empty FIFO at load time yields a zero-phase, not-last symbol.
         if (load_data) begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               phase_n = bit_phase(fifo_rd_data[0]);
               last_n  = fifo_rd_data[1];
            end else begin
               phase_n    = PHASE_0;
               last_n     = 1'b0;
               underrun_n = 1'b1;
            end
         end
      end

      busy_n = (state_n != ST_IDLE);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pre_q        <= '0;
         tail_q       <= 1'b0;
         last_q       <= 1'b0;
         phase_offset <= PHASE_0;
         nco_en       <= 1'b0;
         sym_strobe   <= 1'b0;
         underrun     <= 1'b0;
         busy         <= 1'b0;
         phi_inc      <= BASE_PHASE;
      end else begin
         state_q      <= state_n;
         cnt_q        <= cnt_n;
         pre_q        <= pre_n;
         tail_q       <= tail_n;
         last_q       <= last_n;
         phase_offset <= phase_n;
         nco_en       <= nco_n;
         sym_strobe   <= strobe_n;
         underrun     <= underrun_n;
         busy         <= busy_n;
         phi_inc      <= BASE_PHASE;
      end
   end

endmodule

// File: tb/tb_psk_symbol_scheduler.sv
// tb/tb_psk_symbol_scheduler.sv - directed self-checking bench for psk_symbol_scheduler
module tb_psk_symbol_scheduler;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        frame_start;
   logic        abort;
   logic        bit_valid;
   logic        bit_data;
   logic        bit_last;
   logic        bit_ready;
   logic [31:0] phi_inc;
   logic [15:0] phase_offset;
   logic        nco_en;
   logic        sym_strobe;
   logic        busy;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   psk_symbol_scheduler #(
      .BASE_PHASE    (32'd655),
      .SYM_CYCLES    (4),
      .PREAMBLE_SYMS (2),
      .FIFO_DEPTH    (4)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .frame_start  (frame_start),
      .abort        (abort),
      .bit_valid    (bit_valid),
      .bit_data     (bit_data),
      .bit_last     (bit_last),
      .bit_ready    (bit_ready),
      .phi_inc      (phi_inc),
      .phase_offset (phase_offset),
      .nco_en       (nco_en),
      .sym_strobe   (sym_strobe),
      .busy         (busy),
      .underrun     (underrun)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_bit(input logic d, input logic l);
      bit_valid = 1'b1;
      bit_data  = d;
      bit_last  = l;
      step();
      bit_valid = 1'b0;
      bit_data  = 1'b0;
      bit_last  = 1'b0;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n   = 1'b0;
      frame_start = 1'b0;
      abort       = 1'b0;
      bit_valid   = 1'b0;
      bit_data    = 1'b0;
      bit_last    = 1'b0;
      #12;
      checks++;
      if ({bit_ready, nco_en, sym_strobe, busy, underrun} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000", {bit_ready, nco_en, sym_strobe, busy, underrun});
      end
      checks++;
      if (phi_inc !== 32'd655) begin
         errors++;
         $display("FAIL reset_phi_inc: got %0d expected 655", phi_inc);
      end
      checks++;
      if (phase_offset !== 16'h0000) begin
         errors++;
         $display("FAIL reset_phase: got %h expected 0000", phase_offset);
      end
      sys_rst_n = 1'b1;
      #1;
      checks++;
      if (bit_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b expected 0", bit_ready);
      end
      step();
      checks++;
      if (bit_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_edge: got %b expected 1", bit_ready);
      end
   endtask

   task automatic test_basic_frame();
      logic [15:0] exp_ph [0:6];
      int strobes;
      int busy_cyc;
      exp_ph   = '{16'h0000, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h0000};
      strobes  = 0;
      busy_cyc = 0;
      push_bit(1'b1, 1'b0);
      push_bit(1'b0, 1'b0);
      push_bit(1'b1, 1'b1);
      start_frame();
      for (int i = 0; i < 28; i++) begin
         checks++;
         if (phase_offset !== exp_ph[i / 4]) begin
            errors++;
            $display("FAIL basic_phase[%0d]: got %h expected %h", i, phase_offset, exp_ph[i / 4]);
         end
         checks++;
         if (sym_strobe !== (i % 4 == 0)) begin
            errors++;
            $display("FAIL basic_strobe[%0d]: got %b expected %b", i, sym_strobe, (i % 4 == 0));
         end
         if (sym_strobe === 1'b1) strobes++;
         if (busy === 1'b1) busy_cyc++;
         step();
      end
      checks++;
      if (strobes != 7) begin
         errors++;
         $display("FAIL basic_strobe_count: got %0d expected 7", strobes);
      end
      checks++;
      if (busy_cyc != 28) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d expected 28", busy_cyc);
      end
      checks++;
      if ({busy, nco_en, phase_offset} !== {1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL basic_end_idle: got busy=%b nco=%b ph=%h expected 0 0 0000", busy, nco_en, phase_offset);
      end
   endtask

   task automatic test_underrun();
      int ur_cnt;
      ur_cnt = 0;
      start_frame();
      for (int i = 0; i < 34; i++) begin
         if (i == 18) begin
            bit_valid = 1'b1;
            bit_data  = 1'b1;
            bit_last  = 1'b1;
         end else begin
            bit_valid = 1'b0;
            bit_data  = 1'b0;
            bit_last  = 1'b0;
         end
         if (underrun === 1'b1) ur_cnt++;
         if (i == 8) begin
            checks++;
            if ({underrun, phase_offset} !== {1'b1, 16'h0000}) begin
               errors++;
               $display("FAIL underrun_first_data: got ur=%b ph=%h expected 1 0000", underrun, phase_offset);
            end
         end
         if (i == 9) begin
            checks++;
            if (underrun !== 1'b0) begin
               errors++;
               $display("FAIL underrun_one_cycle: got %b expected 0", underrun);
            end
         end
         if (i == 20) begin
            checks++;
            if ({underrun, phase_offset} !== {1'b0, 16'h8000}) begin
               errors++;
               $display("FAIL underrun_late_bit: got ur=%b ph=%h expected 0 8000", underrun, phase_offset);
            end
         end
         if (i == 24) begin
            checks++;
            if ({busy, phase_offset} !== {1'b1, 16'h0000}) begin
               errors++;
               $display("FAIL underrun_tail: got busy=%b ph=%h expected 1 0000", busy, phase_offset);
            end
         end
         if (i == 32) begin
            checks++;
            if ({busy, nco_en} !== 2'b00) begin
               errors++;
               $display("FAIL underrun_idle: got busy=%b nco=%b expected 0 0", busy, nco_en);
            end
         end
         step();
      end
      checks++;
      if (ur_cnt != 3) begin
         errors++;
         $display("FAIL underrun_count: got %0d expected 3", ur_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  pat;
      logic [15:0] exp_ph [0:4];
      int acc;
      pat    = 5'b10101;
      exp_ph = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h8000};
      acc    = 0;
      bit_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         bit_data = pat[acc];
         bit_last = (acc == 4);
         checks++;
         if (bit_ready !== (c < 4)) begin
            errors++;
            $display("FAIL b2b_ready[%0d]: got %b expected %b", c, bit_ready, (c < 4));
         end
         if (bit_ready === 1'b1) acc++;
         step();
      end
      checks++;
      if (acc != 4) begin
         errors++;
         $display("FAIL b2b_accepted: got %0d expected 4", acc);
      end
      bit_data = pat[4];
      bit_last = 1'b1;
      start_frame();
      for (int i = 0; i < 38; i++) begin
         if (i == 9) begin
            bit_valid = 1'b0;
            bit_data  = 1'b0;
            bit_last  = 1'b0;
         end
         if (i == 0 || i == 7 || i == 9) begin
            checks++;
            if (bit_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_ready_frame[%0d]: got %b expected 0", i, bit_ready);
            end
         end
         if (i == 8) begin
            checks++;
            if (bit_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready_after_pop: got %b expected 1", bit_ready);
            end
         end
         if (i >= 8 && i < 28 && (i % 4 == 0)) begin
            checks++;
            if (phase_offset !== exp_ph[(i - 8) / 4]) begin
               errors++;
               $display("FAIL b2b_phase[%0d]: got %h expected %h", i, phase_offset, exp_ph[(i - 8) / 4]);
            end
         end
         if (i == 28) begin
            checks++;
            if ({busy, phase_offset} !== {1'b1, 16'h0000}) begin
               errors++;
               $display("FAIL b2b_tail: got busy=%b ph=%h expected 1 0000", busy, phase_offset);
            end
         end
         if (i == 36) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle: got %b expected 0", busy);
            end
         end
         step();
      end
   endtask

   task automatic test_abort();
      push_bit(1'b1, 1'b0);
      push_bit(1'b0, 1'b0);
      push_bit(1'b1, 1'b1);
      start_frame();
      for (int i = 0; i < 10; i++) step();
      checks++;
      if ({busy, phase_offset} !== {1'b1, 16'h8000}) begin
         errors++;
         $display("FAIL abort_pre_state: got busy=%b ph=%h expected 1 8000", busy, phase_offset);
      end
      abort       = 1'b1;
      frame_start = 1'b1;
      bit_valid   = 1'b1;
      bit_data    = 1'b1;
      bit_last    = 1'b1;
      step();
      abort       = 1'b0;
      frame_start = 1'b0;
      bit_valid   = 1'b0;
      bit_data    = 1'b0;
      bit_last    = 1'b0;
      checks++;
      if ({busy, nco_en, sym_strobe, phase_offset} !== {3'b000, 16'h0000}) begin
         errors++;
         $display("FAIL abort_outputs: got busy=%b nco=%b stb=%b ph=%h expected 0 0 0 0000", busy, nco_en, sym_strobe, phase_offset);
      end
      checks++;
      if (bit_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready: got %b expected 1", bit_ready);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_start: got %b expected 0", busy);
      end
      start_frame();
      for (int i = 0; i < 8; i++) step();
      checks++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("FAIL abort_fifo_flushed: got underrun=%b expected 1", underrun);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      start_frame();
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (phase_offset !== 16'h8000) begin
         errors++;
         $display("FAIL rst_pre_phase: got %h expected 8000", phase_offset);
      end
      #2;
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({bit_ready, nco_en, sym_strobe, busy, underrun, phase_offset} !== {5'b00000, 16'h0000}) begin
         errors++;
         $display("FAIL rst_async: got flags=%b ph=%h expected 00000 0000", {bit_ready, nco_en, sym_strobe, busy, underrun}, phase_offset);
      end
      checks++;
      if (phi_inc !== 32'd655) begin
         errors++;
         $display("FAIL rst_phi_inc: got %0d expected 655", phi_inc);
      end
      step();
      sys_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if ({busy, nco_en, sym_strobe} !== 3'b000) begin
            errors++;
            $display("FAIL rst_no_resume[%0d]: got busy=%b nco=%b stb=%b expected 0 0 0", i, busy, nco_en, sym_strobe);
         end
      end
      start_frame();
      checks++;
      if ({busy, sym_strobe, phase_offset} !== {2'b11, 16'h0000}) begin
         errors++;
         $display("FAIL rst_restart_sym0: got busy=%b stb=%b ph=%h expected 1 1 0000", busy, sym_strobe, phase_offset);
      end
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({sym_strobe, phase_offset} !== {1'b1, 16'h8000}) begin
         errors++;
         $display("FAIL rst_restart_sym1: got stb=%b ph=%h expected 1 8000", sym_strobe, phase_offset);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_ignore_start();
      push_bit(1'b1, 1'b1);
      start_frame();
      for (int i = 0; i < 22; i++) begin
         frame_start = (i == 10);
         checks++;
         if (sym_strobe !== (i < 20 && i % 4 == 0)) begin
            errors++;
            $display("FAIL ign_strobe[%0d]: got %b expected %b", i, sym_strobe, (i < 20 && i % 4 == 0));
         end
         if (i == 8) begin
            checks++;
            if (phase_offset !== 16'h8000) begin
               errors++;
               $display("FAIL ign_data_phase: got %h expected 8000", phase_offset);
            end
         end
         if (i == 12) begin
            checks++;
            if (phase_offset !== 16'h0000) begin
               errors++;
               $display("FAIL ign_tail_phase: got %h expected 0000", phase_offset);
            end
         end
         if (i == 20) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL ign_idle: got %b expected 0", busy);
            end
         end
         step();
      end
      frame_start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_underrun();
      test_back_to_back();
      test_abort();
      test_reset_mid_frame();
      test_ignore_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/psk_symbol_scheduler.md
PSK_SYMBOL_SCHEDULER -- requirements
Module: psk_symbol_scheduler

Interface
REQ-001 Parameter BASE_PHASE, default 655, is the 32-bit NCO phase increment driven on phi_inc.
REQ-002 Parameter SYM_CYCLES, default 1000, is the number of clocks per symbol; legal values are 2..65535.
REQ-003 Parameter PREAMBLE_SYMS, default 8, is the number of preamble symbols; legal values are 1..255.
REQ-004 Parameter FIFO_DEPTH, default 4, is the number of bit-FIFO entries; it is a power of 2 and at least 2.
REQ-005 sys_clk  in  1  is the single clock; all logic is rising-edge.
REQ-006 sys_rst_n  in  1  is the asynchronous, active-low reset.
REQ-007 frame_start  in  1  is a one-cycle request to begin a frame.
REQ-008 abort  in  1  is a synchronous frame abort and FIFO flush.
REQ-009 bit_valid  in  1  qualifies bit_data and bit_last.
REQ-010 bit_data  in  1  is the payload bit.
REQ-011 bit_last  in  1  marks the final payload bit of the frame.
REQ-012 bit_ready  out  1  is high when the FIFO can accept a bit.
REQ-013 phi_inc  out  32  is the NCO frequency word.
REQ-014 phase_offset  out  16  is the NCO phase offset, either 16'h0000 or 16'h8000.
REQ-015 nco_en  out  1  is the NCO run enable.
REQ-016 sym_strobe  out  1  is high during the first cycle of every symbol.
REQ-017 busy  out  1  is high whenever state is not IDLE.
REQ-018 underrun  out  1  is a one-cycle pulse when a data symbol finds the FIFO empty.

Function
REQ-019 The block SHALL implement states IDLE, PREAMBLE, DATA and TAIL.
REQ-020 A push SHALL occur on bit_valid && bit_ready, in any state; bit_ready SHALL equal !full.
REQ-021 Each FIFO entry SHALL store {bit_last, bit_data}.
REQ-022 The symbol counter SHALL count 0..SYM_CYCLES-1 outside IDLE and be held at 0 in IDLE.
REQ-023 A "wrap" is the edge at which the counter equals SYM_CYCLES-1; at a wrap the counter returns to 0.
REQ-024 In IDLE, frame_start SHALL move the state to PREAMBLE on the next edge, with counter 0, nco_en 1 and preamble index 0.
REQ-025 frame_start SHALL be ignored outside IDLE.
REQ-026 Preamble symbol k SHALL drive phase_offset 16'h0000 when k is even and 16'h8000 when k is odd.
REQ-027 The wrap ending preamble symbol PREAMBLE_SYMS-1 SHALL move the state to DATA and load the first data symbol.
REQ-028 Loading a data symbol SHALL pop one FIFO entry and set phase_offset to bit_data ? 16'h8000 : 16'h0000.
REQ-029 If the FIFO is empty at a data-symbol load, phase_offset SHALL be 0, underrun SHALL pulse in the first cycle of that symbol, and the symbol SHALL be treated as not-last.
REQ-030 The wrap ending a symbol loaded with bit_last=1 SHALL move the state to TAIL with phase_offset 0 and no pop.
REQ-031 TAIL SHALL last exactly 2 symbols; its final wrap SHALL return the state to IDLE with nco_en 0 and phase_offset 0.
REQ-032 sym_strobe SHALL be high in the first cycle of every PREAMBLE, DATA and TAIL symbol, including the first preamble symbol.
REQ-033 phase_offset SHALL change only on symbol-load edges and be stable for all SYM_CYCLES cycles of a symbol.
REQ-034 A simultaneous push and pop SHALL both succeed, leaving the FIFO count unchanged; a push while full SHALL not occur.
REQ-035 abort SHALL, on the next edge, force IDLE, flush the FIFO, and clear the counter, nco_en and phase_offset.
REQ-036 abort SHALL override frame_start and any push in the same cycle.
REQ-037 phi_inc SHALL be a register loaded with BASE_PHASE, constant after reset.
REQ-038 All outputs SHALL be registered.

Reset
REQ-039 On sys_rst_n low, asynchronously, the block SHALL enter IDLE with the FIFO empty and the counter 0.
REQ-040 On sys_rst_n low, bit_ready SHALL be 0, phi_inc BASE_PHASE, phase_offset 0, and nco_en, sym_strobe, busy and underrun 0.
REQ-041 bit_ready SHALL rise on the first edge after reset release.
REQ-042 Reset mid-frame SHALL discard all frame state; no symbol SHALL resume after release.

Structure
REQ-043 A shared package SHALL hold the state enumeration, PHASE_0 = 16'h0000 and PHASE_180 = 16'h8000.
REQ-044 The FIFO SHALL be a separate sub-module, bit_fifo (2-bit wide, FIFO_DEPTH deep, full and empty flags).

Verification (bench parameters: SYM_CYCLES=4, PREAMBLE_SYMS=2, FIFO_DEPTH=4)
REQ-045 Push bits 1,0,1(last), then frame_start -> phase_offset sequence 0,8000 (preamble), 8000,0,8000 (data), 0,0 (tail), 4 cycles each; busy 28 cycles; 7 sym_strobe pulses.
REQ-046 frame_start with the FIFO empty, then push 1(last) 10 cycles into DATA -> underrun pulses at first data symbol start; later symbol offset 8000; then TAIL, then IDLE.
REQ-047 Push 5 bits back-to-back in IDLE -> bit_ready low after 4 accepted; 5th accepted only after first pop.
REQ-048 abort asserted with frame_start and bit_valid while 2 bits are queued mid-DATA -> next cycle IDLE, FIFO empty, nco_en 0, no push.
REQ-049 sys_rst_n asserted mid-preamble -> outputs at reset values immediately; after release, frame_start restarts with preamble symbol 0 offset 0.
REQ-050 frame_start pulsed during DATA -> ignored; symbol timing unchanged.
